// File: rtl/mem_pkg.sv
// Shared constants for the boot-loaded unified memory: RV32I load/store func3 codes,
// loader state encoding and the NOP returned while the image is still streaming in.
package mem_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {ST_LOAD, ST_RUN} state_e;
endpackage

// File: rtl/mem_lsu_align.sv
// Combinational LSU lane logic: byte enables, store lane replication, load extract/extend
// and alignment / illegal-func3 detection for one 32-bit word access.
module mem_lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic        write_en,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic        err,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata
);
  logic        st_err;
  logic        ld_err;
  logic [15:0] rlo;

  always_comb begin
    byte_en    = '0;
    wdata_lane = '0;
    rdata      = '0;
    st_err     = 1'b0;
    ld_err     = 1'b0;
    rlo        = 16'(rword >> {addr_lo, 3'b000});

    // Store data is replicated across lanes; byte enables pick the live ones.
    case (func3)
      F3_SB: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      F3_SH: begin
        st_err     = addr_lo[0];
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      F3_SW: begin
        st_err     = (addr_lo != 2'b00);
        byte_en    = 4'b1111;
        wdata_lane = wdata;
      end
      default: st_err = 1'b1;
    endcase

    case (func3)
      F3_LB:  rdata = {{24{rlo[7]}}, rlo[7:0]};
      F3_LBU: rdata = {24'h0, rlo[7:0]};
      F3_LH: begin
        ld_err = addr_lo[0];
        rdata  = {{16{rlo[15]}}, rlo};
      end
      F3_LHU: begin
        ld_err = addr_lo[0];
        rdata  = {16'h0, rlo};
      end
      F3_LW: begin
        ld_err = (addr_lo != 2'b00);
        rdata  = rword;
      end
      default: ld_err = 1'b1;
    endcase

    err = write_en ? st_err : ld_err;
    if (err) begin
      byte_en = '0;
      rdata   = '0;
    end
  end
endmodule

// File: rtl/boot_loaded_mem.sv
// Unified instruction/data memory filled at runtime by a valid/ready loader stream,
// then serving multi-slot fetches and RV32I byte/half/word loads and stores.
module boot_loaded_mem
  import mem_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH_WORDS = 16384,
  parameter int ADDR_W      = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_reset,
  input  logic                          io_ld_valid,
  output logic                          io_ld_ready,
  input  logic [31:0]                   io_ld_data,
  input  logic                          io_ld_last,
  output logic                          io_init_done,
  output logic [$clog2(DEPTH_WORDS):0]  io_ld_count,
  output logic                          io_ld_overflow,
  input  logic [ADDR_W-1:0]             io_if_mem_instAddr,
  output logic [32*FETCH_WIDTH-1:0]     io_mem_id_inst,
  input  logic [ADDR_W-1:0]             io_ex_mem_dataAddr,
  input  logic                          io_ex_mem_writeEn,
  input  logic [31:0]                   io_ex_mem_writeData,
  input  logic [2:0]                    io_ex_mem_func3,
  output logic [31:0]                   io_mem_lsu_data,
  output logic                          io_mem_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             run;
  logic             ld_wr;
  logic             st_wr;
  logic [IDX_W-1:0] d_idx;
  logic [IDX_W-1:0] f_idx;
  logic [31:0]      d_word;
  logic [3:0]       lsu_be;
  logic             lsu_err;
  logic [31:0]      lsu_wdata;
  logic [31:0]      lsu_rdata;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  logic             unused_addr_bits;

  assign run    = (state_q == ST_RUN);
  assign d_idx  = io_ex_mem_dataAddr[IDX_W+1:2];
  assign f_idx  = io_if_mem_instAddr[IDX_W+1:2];
  assign d_word = mem[d_idx];

  // Upper address bits are deliberately ignored so accesses wrap modulo the array.
  assign unused_addr_bits = ^{io_if_mem_instAddr[ADDR_W-1:IDX_W+2], io_if_mem_instAddr[1:0],
                              io_ex_mem_dataAddr[ADDR_W-1:IDX_W+2]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ld_wr   = 1'b0;
    // Soft reset wins over a same-cycle handshake; that word is dropped.
    if (io_reset) begin
      state_d = ST_LOAD;
      ptr_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (io_ld_valid && state_q == ST_LOAD) begin
      ld_wr = 1'b1;
      ptr_d = ptr_q + IDX_W'(1);
      cnt_d = cnt_q + (IDX_W+1)'(1);
      if (io_ld_last) begin
        state_d = ST_RUN;
      end else if (ptr_q == '1) begin
        state_d = ST_RUN;
        ovf_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  mem_lsu_align u_align (
    .func3      (io_ex_mem_func3),
    .addr_lo    (io_ex_mem_dataAddr[1:0]),
    .write_en   (io_ex_mem_writeEn),
    .wdata      (io_ex_mem_writeData),
    .rword      (d_word),
    .byte_en    (lsu_be),
    .err        (lsu_err),
    .wdata_lane (lsu_wdata),
    .rdata      (lsu_rdata)
  );

  assign st_wr = run && io_ex_mem_writeEn && !lsu_err;

  // Loader writes only happen in LOAD and stores only in RUN, so one port suffices.
  always_comb begin
    wr_en   = ld_wr || st_wr;
    wr_idx  = ld_wr ? ptr_q : d_idx;
    wr_be   = ld_wr ? 4'hF : lsu_be;
    wr_data = ld_wr ? io_ld_data : lsu_wdata;
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
    logic [IDX_W-1:0] slot_idx;
    assign slot_idx = f_idx + IDX_W'(k);
    assign io_mem_id_inst[32*k +: 32] = run ? mem[slot_idx] : NOP_INST;
  end

  assign io_ld_ready     = (state_q == ST_LOAD);
  assign io_init_done    = run;
  assign io_ld_count     = cnt_q;
  assign io_ld_overflow  = ovf_q;
  assign io_mem_err      = lsu_err;
  assign io_mem_lsu_data = (run && !lsu_err) ? lsu_rdata : 32'h0;
endmodule

// File: tb/tb_boot_loaded_mem.sv
// Bench for boot_loaded_mem: directed vector table, hand sequences for loader corner
// cases, and randomized loads/stores/fetches against an array-based reference model.
module tb_boot_loaded_mem;
  localparam int D  = 16384;
  localparam int CW = $clog2(D) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clock = 0, reset = 0, io_reset = 0, ld_valid = 0, ld_last = 0;
  logic [31:0] ld_data = 0, wdata = 0;
  logic [63:0] if_addr = 0, d_addr = 0;
  logic wen = 0;
  logic [2:0] f3 = 0;
  logic ready, done, ovf, err;
  logic [CW-1:0] count;
  logic [63:0] inst;
  logic [31:0] lsu;

  logic r8 = 0, v8 = 0, l8 = 0;
  logic [31:0] d8 = 0;
  logic [63:0] ifa8 = 0;
  logic ready8, done8, ovf8, err8;
  logic [3:0] cnt8;
  logic [63:0] inst8;
  logic [31:0] lsu8;

  int checks = 0, errors = 0;
  logic [31:0] mdl [64];

  always #5 clock = ~clock;

  boot_loaded_mem #(.FETCH_WIDTH(2), .DEPTH_WORDS(D), .ADDR_W(64)) dut (
    .clock(clock), .reset(reset), .io_reset(io_reset),
    .io_ld_valid(ld_valid), .io_ld_ready(ready), .io_ld_data(ld_data), .io_ld_last(ld_last),
    .io_init_done(done), .io_ld_count(count), .io_ld_overflow(ovf),
    .io_if_mem_instAddr(if_addr), .io_mem_id_inst(inst),
    .io_ex_mem_dataAddr(d_addr), .io_ex_mem_writeEn(wen), .io_ex_mem_writeData(wdata),
    .io_ex_mem_func3(f3), .io_mem_lsu_data(lsu), .io_mem_err(err));

  boot_loaded_mem #(.FETCH_WIDTH(2), .DEPTH_WORDS(8), .ADDR_W(64)) dut8 (
    .clock(clock), .reset(reset), .io_reset(r8),
    .io_ld_valid(v8), .io_ld_ready(ready8), .io_ld_data(d8), .io_ld_last(l8),
    .io_init_done(done8), .io_ld_count(cnt8), .io_ld_overflow(ovf8),
    .io_if_mem_instAddr(ifa8), .io_mem_id_inst(inst8),
    .io_ex_mem_dataAddr(64'h0), .io_ex_mem_writeEn(1'b0), .io_ex_mem_writeData(32'h0),
    .io_ex_mem_func3(3'b010), .io_mem_lsu_data(lsu8), .io_mem_err(err8));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reference for one access, straight from the ISA rules.
  function automatic void ref_op(input logic w_en, input logic [2:0] fn, input int a,
                                 input logic [31:0] w, output logic e, output logic [31:0] d);
    int sh = 8 * (a % 4);
    logic [31:0] b = (w >> sh) & 32'hFF;
    logic [31:0] h = (w >> sh) & 32'hFFFF;
    d = 0;
    if (w_en) e = !(fn == 0 || (fn == 1 && a % 2 == 0) || (fn == 2 && a % 4 == 0));
    else begin
      case (fn)
        3'd0: begin e = 0; d = (b >= 128) ? b + 32'hFFFF_FF00 : b; end
        3'd4: begin e = 0; d = b; end
        3'd1: begin e = (a % 2 != 0); d = (h >= 32768) ? h + 32'hFFFF_0000 : h; end
        3'd5: begin e = (a % 2 != 0); d = h; end
        3'd2: begin e = (a % 4 != 0); d = w; end
        default: e = 1;
      endcase
      if (e) d = 0;
    end
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] fn,
                                            input int a, input logic [31:0] v);
    int sh = 8 * (a % 4);
    logic [31:0] mask = (fn == 0) ? 32'hFF : (fn == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    return (w & ~(mask << sh)) | ((v & mask) << sh);
  endfunction

  typedef struct {
    logic        wen;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic        chk_d;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vecs[19];
  logic [31:0] img[4];

  initial begin
    img = '{32'h0011_2233, 32'h8899_AABB, 32'h3333_3333, 32'h4444_4444};
    vecs = '{
      '{0, 3'd0, 64'h7, 0, 1, 32'hFFFF_FF88, 0},
      '{0, 3'd4, 64'h7, 0, 1, 32'h0000_0088, 0},
      '{0, 3'd1, 64'h6, 0, 1, 32'hFFFF_8899, 0},
      '{1, 3'd2, 64'h6, 32'h1234_5678, 1, 32'h0, 1},
      '{0, 3'd1, 64'h3, 0, 1, 32'h0, 1},
      '{0, 3'd2, 64'h4, 0, 1, 32'h8899_CCBB, 0},
      '{0, 3'd3, 64'h0, 0, 1, 32'h0, 1},
      '{0, 3'd6, 64'h0, 0, 1, 32'h0, 1},
      '{1, 3'd4, 64'h4, 32'hFFFF_FFFF, 1, 32'h0, 1},
      '{0, 3'd2, 64'h4, 0, 1, 32'h8899_CCBB, 0},
      '{1, 3'd1, 64'h6, 32'h0000_BEEF, 0, 32'h0, 0},
      '{0, 3'd2, 64'h4, 0, 1, 32'hBEEF_CCBB, 0},
      '{0, 3'd5, 64'h6, 0, 1, 32'h0000_BEEF, 0},
      '{0, 3'd1, 64'h6, 0, 1, 32'hFFFF_BEEF, 0},
      '{0, 3'd0, 64'hFFFF_0000_0000_0004, 0, 1, 32'hFFFF_FFBB, 0},
      '{1, 3'd2, 64'h8, 32'hCAFE_F00D, 0, 32'h0, 0},
      '{0, 3'd2, 64'h8, 0, 1, 32'hCAFE_F00D, 0},
      '{0, 3'd4, 64'hA, 0, 1, 32'h0000_00FE, 0},
      '{1, 3'd1, 64'h1, 32'h1, 1, 32'h0, 1}
    };

    // Reset and pre-load behaviour
    repeat (3) @(posedge clock);
    #1;
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 1);
    reset = 1;
    if_addr = 0;
    #1;
    chk("load_fetch_nop", inst, {NOP, NOP});

    ld_valid = 1; ld_data = img[0];
    tick;
    ld_valid = 0;
    wen = 1; f3 = 3'd2; d_addr = 0; wdata = 32'hDEAD_BEEF;
    tick;
    wen = 0;
    chk("count_after_1", count, 1);
    for (int i = 1; i < 4; i++) begin
      ld_valid = 1; ld_data = img[i]; ld_last = (i == 3);
      #1 chk("done_before_last", done, 0);
      tick;
    end
    ld_valid = 0; ld_last = 0;
    f3 = 3'd2; d_addr = 0;
    #1;
    chk("count_4", count, 4);
    chk("init_done", done, 1);
    chk("ready_run", ready, 0);
    chk("fetch_0", inst, {img[1], img[0]});
    chk("sw_in_load_ignored", lsu, img[0]);

    // Directed vectors, with the read-during-write store sequence spliced in after 3
    for (int i = 0; i < 19; i++) begin
      if (i == 3) begin
        wen = 1; f3 = 3'd0; d_addr = 64'h5; wdata = 32'h0000_00CC; if_addr = 64'h4;
        #1 chk("fetch_old_during_sb", inst[31:0], 32'h8899_AABB);
        tick;
        wen = 0; f3 = 3'd2; d_addr = 64'h4;
        #1 chk("lw_after_sb", lsu, 32'h8899_CCBB);
        chk("fetch_new_after_sb", inst[31:0], 32'h8899_CCBB);
      end
      wen = vecs[i].wen; f3 = vecs[i].f3; d_addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_err", i), err, vecs[i].exp_e);
      if (vecs[i].chk_d) chk($sformatf("vec%0d_data", i), lsu, vecs[i].exp_d);
      tick;
    end
    wen = 0;

    // Overflow on an 8-word array
    for (int i = 0; i < 9; i++) begin
      v8 = 1; d8 = 32'hA0 + i;
      #1 chk("ovf8_ready", ready8, (i < 8));
      tick;
      chk("ovf8_flag", ovf8, (i >= 7));
    end
    v8 = 0; ifa8 = 64'h1C;
    #1;
    chk("ovf8_done", done8, 1);
    chk("ovf8_count", cnt8, 8);
    chk("ovf8_wrap_fetch", inst8, {32'hA0, 32'hA7});
    r8 = 1;
    tick;
    r8 = 0;
    chk("soft_rst_count", cnt8, 0);
    chk("soft_rst_ovf", ovf8, 0);
    chk("soft_rst_ready", ready8, 1);
    chk("soft_rst_nop", inst8, {NOP, NOP});
    v8 = 1; d8 = 32'h55; r8 = 1;
    tick;
    r8 = 0;
    chk("soft_rst_priority", cnt8, 0);
    d8 = 32'h66; l8 = 1;
    tick;
    v8 = 0; l8 = 0; ifa8 = 0;
    #1;
    chk("reload_count", cnt8, 1);
    chk("reload_done", done8, 1);
    chk("reload_kept", inst8, {32'hA1, 32'h66});

    // Randomized: reload 64 words with gaps, then random accesses
    io_reset = 1;
    tick;
    io_reset = 0;
    chk("rand_rst_done", done, 0);
    begin
      int n = 0, cyc = 0;
      while (n < 64 && cyc < 2000) begin
        ld_valid = ($urandom % 2) == 1; ld_data = $urandom; ld_last = (n == 63);
        #1 chk("rand_ld_ready", ready, 1);
        tick;
        if (ld_valid) begin mdl[n] = ld_data; n++; end
        cyc++;
      end
      ld_valid = 0; ld_last = 0;
      chk("rand_ld_words", n, 64);
    end
    chk("rand_done", done, 1);
    chk("rand_count", count, 64);
    for (int t = 0; t < 400; t++) begin
      int ba, fi;
      logic e_exp;
      logic [31:0] d_exp;
      ba = $urandom_range(0, 255);
      fi = $urandom_range(0, 62);
      wen = ($urandom % 3) == 0; f3 = 3'($urandom); wdata = $urandom;
      d_addr = {$urandom, 16'h0, 16'(ba)};
      if_addr = {$urandom, 16'h0, 16'(fi * 4)};
      ref_op(wen, f3, ba, mdl[ba / 4], e_exp, d_exp);
      #1;
      chk("rand_err", err, e_exp);
      if (!wen) chk("rand_data", lsu, d_exp);
      chk("rand_fetch", inst, {mdl[fi + 1], mdl[fi]});
      tick;
      if (wen && !e_exp) mdl[ba / 4] = ref_store(mdl[ba / 4], f3, ba, wdata);
    end
    wen = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
